axis_reg_slice_chain: RTL and testbench

Parametrised AXI4-Stream register slice chain for the decompression datapath. It breaks long timing paths between the decompressor core and the C2S DMA interface. It carries tdata/tkeep/tlast through STAGES register stages with full backpressure support and sustains one beat per cycle. Optional per-stage skid buffers make every stage's tready a registered signal. A wrapping packet counter and a live occupancy count are exposed for debug and monitoring.

---
 rtl/axis_reg_slice_chain.sv | 168 ++++++++++++++++
 tb/tb_axis_reg_slice_chain.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_reg_slice_chain.sv
// AXI4-Stream register slice chain: STAGES cascaded slices (skid or single-register)
// carrying tdata/tkeep/tlast, plus occupancy and delivered-packet counters.

module axis_reg_slice_stage #(
    parameter int W    = 8,
    parameter int SKID = 1
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
            state_t       state, state_nxt;
            logic [W-1:0] main_q, skid_q;
            logic         ready_q;
            logic         in_fire, out_fire;
            logic         load_main, load_skid, main_from_skid;

            assign in_fire  = in_valid && ready_q;
            assign out_fire = (state != EMPTY) && out_ready;

            always_comb begin
                state_nxt      = state;
                load_main      = 1'b0;
                load_skid      = 1'b0;
                main_from_skid = 1'b0;
                case (state)
                    EMPTY: if (in_fire) begin
                        load_main = 1'b1;
                        state_nxt = ONE;
                    end
                    ONE: begin
                        if (in_fire && !out_fire) begin
                            load_skid = 1'b1;
                            state_nxt = FULL;
                        end else if (in_fire && out_fire) begin
                            load_main = 1'b1;
                        end else if (out_fire) begin
                            state_nxt = EMPTY;
                        end
                    end
                    FULL: if (out_fire) begin
                        main_from_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                    default: state_nxt = EMPTY;
                endcase
            end

            // tready is registered from the next state so it never depends on out_ready
            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    state   <= state_nxt;
                    ready_q <= (state_nxt != FULL);
                    if (load_main)           main_q <= in_data;
                    else if (main_from_skid) main_q <= skid_q;
                    if (load_skid)           skid_q <= in_data;
                end
            end

            assign in_ready  = ready_q;
            assign out_valid = (state != EMPTY);
            assign out_data  = main_q;
        end else begin : g_reg
            logic         valid_q;
            logic [W-1:0] data_q;

            assign in_ready = !valid_q || out_ready;

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else if (in_ready) begin
                    valid_q <= in_valid;
                    if (in_valid) data_q <= in_data;
                end
            end

            assign out_valid = valid_q;
            assign out_data  = data_q;
        end
    endgenerate
endmodule

module axis_reg_slice_chain #(
    parameter int DATA_W = 256,
    parameter int KEEP_W = DATA_W / 8,
    parameter int STAGES = 2,
    parameter int SKID   = 1,
    parameter int OCC_W  = $clog2(2 * STAGES + 1)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [OCC_W-1:0]  occupancy,
    output logic [31:0]       pkt_count
);
    localparam int BW = DATA_W + KEEP_W + 1;

    logic [STAGES:0][BW-1:0] link_data;
    logic [STAGES:0]         link_valid;
    logic [STAGES:0]         link_ready;
    logic                    ready_en;
    logic                    s_fire, m_fire;

    // ready_en keeps the input closed for the first cycle out of reset
    always_ff @(posedge aclk) begin
        if (!aresetn) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    assign link_data[0]  = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    assign link_valid[0] = s_axis_tvalid && ready_en;
    assign s_axis_tready = link_ready[0] && ready_en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        axis_reg_slice_stage #(.W(BW), .SKID(SKID)) u_stage (
            .aclk      (aclk),
            .aresetn   (aresetn),
            .in_data   (link_data[k]),
            .in_valid  (link_valid[k]),
            .in_ready  (link_ready[k]),
            .out_data  (link_data[k+1]),
            .out_valid (link_valid[k+1]),
            .out_ready (link_ready[k+1])
        );
    end

    assign link_ready[STAGES] = m_axis_tready;
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = link_data[STAGES];
    assign m_axis_tvalid = link_valid[STAGES];

    assign s_fire = s_axis_tvalid && s_axis_tready;
    assign m_fire = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            occupancy <= '0;
            pkt_count <= '0;
        end else begin
            if (s_fire && !m_fire)      occupancy <= occupancy + OCC_W'(1);
            else if (!s_fire && m_fire) occupancy <= occupancy - OCC_W'(1);
            if (m_fire && m_axis_tlast) pkt_count <= pkt_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_axis_reg_slice_chain.sv
// Bench for axis_reg_slice_chain: five chain configurations run side by side, each with
// a queue-based reference model fed by its driver and drained by an independent monitor.
`timescale 1ns/1ps

module tb_axis_reg_slice_chain;
    localparam int DW   = 32;
    localparam int KW   = 4;
    localparam int NCFG = 5;

    function automatic int cfg_st(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            2:       return 4;
            3:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_sk(input int i);
        case (i)
            0, 1, 3: return 1;
            default: return 0;
        endcase
    endfunction

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    bit done [NCFG];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g
        localparam int ST  = cfg_st(gi);
        localparam int SK  = cfg_sk(gi);
        localparam int CAP = (SK != 0) ? 2 * ST : ST;
        localparam int OW  = $clog2(2 * ST + 1);

        typedef struct packed {
            logic [DW-1:0] d;
            logic [KW-1:0] k;
            logic          l;
        } beat_t;

        logic          rstn = 1'b0;
        beat_t         sb   = '0;
        logic          sv   = 1'b0;
        logic          mr   = 1'b0;
        logic          sr, mv, ml;
        logic [DW-1:0] md;
        logic [KW-1:0] mk;
        logic [OW-1:0] occ;
        logic [31:0]   pc;

        beat_t       exp_q[$];
        logic [31:0] exp_pkts = '0;

        axis_reg_slice_chain #(
            .DATA_W(DW), .KEEP_W(KW), .STAGES(ST), .SKID(SK), .OCC_W(OW)
        ) dut (
            .aclk          (aclk),
            .aresetn       (rstn),
            .s_axis_tdata  (sb.d),
            .s_axis_tkeep  (sb.k),
            .s_axis_tlast  (sb.l),
            .s_axis_tvalid (sv),
            .s_axis_tready (sr),
            .m_axis_tdata  (md),
            .m_axis_tkeep  (mk),
            .m_axis_tlast  (ml),
            .m_axis_tvalid (mv),
            .m_axis_tready (mr),
            .occupancy     (occ),
            .pkt_count     (pc)
        );

        function automatic string nm(input string s);
            return $sformatf("cfg%0d_st%0d_skid%0d_%s", gi, ST, SK, s);
        endfunction

        function automatic beat_t rnd_beat();
            beat_t b;
            b.d = DW'($urandom);
            b.k = KW'($urandom);
            b.l = ($urandom_range(0, 3) == 0);
            return b;
        endfunction

        // Apply inputs for one cycle; fire tells whether the coming edge takes the beat.
        task automatic step(input logic v, input logic r, input beat_t b, output logic fire);
            @(negedge aclk);
            sv = v;
            mr = r;
            sb = b;
            #1;
            fire = sv && sr;
            if (fire) exp_q.push_back(sb);
        endtask

        // Monitor: compares every delivered beat with the model and checks hold stability.
        initial begin
            logic  hold = 1'b0;
            beat_t held = '0;
            beat_t e;
            forever begin
                @(negedge aclk);
                #2;
                if (!rstn) begin
                    hold = 1'b0;
                    continue;
                end
                if (hold) chk(nm("stable_hold"), {mv, md, mk, ml}, {1'b1, held});
                chk(nm("occupancy"), 64'(occ), 64'(exp_q.size() - int'(sv && sr)));
                chk(nm("pkt_count"), 64'(pc), 64'(exp_pkts));
                if (mv && mr) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL %s: got beat %0h, none expected", nm("beat"), {md, mk, ml});
                    end else begin
                        e = exp_q.pop_front();
                        chk(nm("beat"), 64'({md, mk, ml}), 64'(e));
                        if (e.l) exp_pkts = exp_pkts + 32'd1;
                    end
                end
                hold = mv && !mr;
                held = {md, mk, ml};
            end
        end

        // Driver
        initial begin
            logic  f;
            int    acc;
            int    cyc;
            int    target;
            beat_t b;
            beat_t z;
            z = '0;

            rstn = 1'b0;
            repeat (3) step(1'b0, 1'b0, z, f);
            chk(nm("rst_s_ready"), sr, 0);
            chk(nm("rst_m_valid"), mv, 0);
            chk(nm("rst_m_data"), 64'({md, mk, ml}), 0);
            chk(nm("rst_occ"), occ, 0);
            chk(nm("rst_pkt"), pc, 0);
            @(negedge aclk);
            rstn = 1'b1;
            #1;
            chk(nm("ready_en_gate"), sr, 0);
            step(1'b0, 1'b1, z, f);
            chk(nm("ready_after_release"), sr, 1);

            // single beat latency
            b.d = 32'hA5A5_0000;
            b.k = '1;
            b.l = 1'b0;
            step(1'b1, 1'b1, b, f);
            chk(nm("first_accept"), f, 1);
            for (int k = 0; k < ST; k++) begin
                step(1'b0, 1'b1, z, f);
                chk(nm("latency_m_valid"), mv, (k == ST - 1));
            end

            // back-to-back packet of 16 beats
            for (int i = 0; i < 16; i++) begin
                b.d = DW'(i);
                b.k = '1;
                b.l = (i == 15);
                step(1'b1, 1'b1, b, f);
                chk(nm("stream_accept"), f, 1);
                if (i >= ST) chk(nm("stream_m_valid"), mv, 1);
            end
            repeat (ST + 2) step(1'b0, 1'b1, z, f);
            chk(nm("stream_pkts"), pc, 1);
            chk(nm("stream_drained"), exp_q.size(), 0);

            // full stall: chain must absorb exactly its capacity
            acc = 0;
            for (int c = 0; c < 3 * CAP + 4; c++) begin
                b = rnd_beat();
                step(1'b1, 1'b0, b, f);
                if (f) acc++;
            end
            chk(nm("stall_accepted"), acc, CAP);
            chk(nm("stall_s_ready"), sr, 0);
            chk(nm("stall_occ"), occ, CAP);
            for (int c = 0; c < 2 * CAP + 4; c++) begin
                b = rnd_beat();
                step(1'b1, 1'b1, b, f);
            end
            repeat (CAP + ST + 4) step(1'b0, 1'b1, z, f);
            chk(nm("stall_drained"), exp_q.size(), 0);

            // random valid/ready
            acc = 0;
            cyc = 0;
            while (acc < 1000 && cyc < 20000) begin
                b = rnd_beat();
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b, f);
                if (f) acc++;
                cyc++;
            end
            chk(nm("random_accepted"), acc, 1000);
            repeat (CAP + ST + 4) step(1'b0, 1'b1, z, f);
            chk(nm("random_drained"), exp_q.size(), 0);

            // reset with a partial packet held
            target = (CAP < 3) ? CAP : 3;
            acc = 0;
            cyc = 0;
            while (acc < target && cyc < 50) begin
                b = rnd_beat();
                b.l = 1'b0;
                step(1'b1, 1'b0, b, f);
                if (f) acc++;
                cyc++;
            end
            step(1'b0, 1'b0, z, f);
            chk(nm("pre_reset_occ"), occ, target);
            @(negedge aclk);
            rstn = 1'b0;
            sv = 1'b0;
            mr = 1'b1;
            exp_q.delete();
            exp_pkts = '0;
            @(negedge aclk);
            #1;
            chk(nm("midrst_m_valid"), mv, 0);
            chk(nm("midrst_s_ready"), sr, 0);
            chk(nm("midrst_occ"), occ, 0);
            chk(nm("midrst_pkt"), pc, 0);
            @(negedge aclk);
            rstn = 1'b1;
            #1;
            chk(nm("midrst_ready_en_gate"), sr, 0);
            step(1'b0, 1'b1, z, f);
            chk(nm("midrst_ready_after"), sr, 1);
            repeat (ST + 2) step(1'b0, 1'b1, z, f);
            chk(nm("midrst_no_stale"), mv, 0);

            // packet counter wrap
            @(negedge aclk);
            force dut.pkt_count = 32'hFFFF_FFFF;
            exp_pkts = 32'hFFFF_FFFF;
            #1;
            release dut.pkt_count;
            step(1'b0, 1'b1, z, f);
            chk(nm("wrap_hold"), pc, 32'hFFFF_FFFF);
            b = rnd_beat();
            b.l = 1'b1;
            step(1'b1, 1'b1, b, f);
            chk(nm("wrap_accept"), f, 1);
            repeat (ST + 2) step(1'b0, 1'b1, z, f);
            chk(nm("wrap_pkt"), pc, 0);

            done[gi] = 1'b1;
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int c = 0; c < 60000 && !all_done; c++) begin
            @(negedge aclk);
            all_done = 1'b1;
            for (int i = 0; i < NCFG; i++) if (!done[i]) all_done = 1'b0;
        end
        if (!all_done) begin
            checks++;
            errors++;
            $display("FAIL timeout: not all configurations completed within the cycle budget");
        end
        repeat (3) @(negedge aclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
